// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between two M-stage lanes. When both lanes access
// memory together, lane 1 (older) goes first and lane 2 follows after a one-cycle stall.
module mem_port_arbiter #(
  parameter int D_WIDTH = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_MemWrite1M,
  input  logic               i_MemtoReg1M,
  input  logic [D_WIDTH-1:0] i_ALUResult1M,
  input  logic [D_WIDTH-1:0] i_WriteData1M,
  input  logic               i_MemWrite2M,
  input  logic               i_MemtoReg2M,
  input  logic [D_WIDTH-1:0] i_ALUResult2M,
  input  logic [D_WIDTH-1:0] i_WriteData2M,
  input  logic [D_WIDTH-1:0] i_DMemRData,
  output logic [D_WIDTH-1:0] o_DMemAddr,
  output logic [D_WIDTH-1:0] o_DMemWData,
  output logic               o_DMemWE,
  output logic               o_DMemRE,
  output logic [D_WIDTH-1:0] o_ReadData1M,
  output logic [D_WIDTH-1:0] o_ReadData2M,
  output logic               o_StallM,
  output logic [CNT_W-1:0]   o_ConflictCnt
);

  typedef enum logic {
    IDLE   = 1'b0,
    SERVE2 = 1'b1
  } state_t;

  state_t             state, state_next;
  logic               req1, req2;
  logic               serve1, serve2;
  logic               conflict;
  logic [D_WIDTH-1:0] hold_q;

  assign req1 = i_MemWrite1M | i_MemtoReg1M;
  assign req2 = i_MemWrite2M | i_MemtoReg2M;

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_next = state;
    serve1     = 1'b0;
    serve2     = 1'b0;
    conflict   = 1'b0;
    o_StallM   = 1'b0;
    case (state)
      IDLE: begin
        if (req1) begin
          serve1 = 1'b1;
          if (req2) begin
            conflict   = 1'b1;
            o_StallM   = 1'b1;
            state_next = SERVE2;
          end
        end else if (req2) begin
          serve2 = 1'b1;
        end
      end
      // Lane 1 already completed; its inputs are held only because the pipe is frozen.
      SERVE2: begin
        serve2     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_DMemAddr  = '0;
    o_DMemWData = '0;
    o_DMemWE    = 1'b0;
    o_DMemRE    = 1'b0;
    if (serve1) begin
      o_DMemAddr  = i_ALUResult1M;
      o_DMemWData = i_WriteData1M;
      o_DMemWE    = i_MemWrite1M;
      o_DMemRE    = i_MemtoReg1M;
    end else if (serve2) begin
      o_DMemAddr  = i_ALUResult2M;
      o_DMemWData = i_WriteData2M;
      o_DMemWE    = i_MemWrite2M;
      o_DMemRE    = i_MemtoReg2M;
    end
  end

  always_comb begin
    o_ReadData1M = '0;
    o_ReadData2M = '0;
    if (state == SERVE2) begin
      o_ReadData1M = hold_q;
    end else if (serve1) begin
      o_ReadData1M = i_DMemRData;
    end
    if (serve2) begin
      o_ReadData2M = i_DMemRData;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      hold_q        <= '0;
      o_ConflictCnt <= '0;
    end else begin
      state <= state_next;
      if (conflict) begin
        hold_q <= i_DMemRData;
        if (o_ConflictCnt != {CNT_W{1'b1}}) begin
          o_ConflictCnt <= o_ConflictCnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small combinational-read data memory
// model; the conflict counter is narrowed so saturation is reachable quickly.
module tb_mem_port_arbiter;

  localparam int D_WIDTH = 32;
  localparam int CNT_W   = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               mem_write1, mem_to_reg1, mem_write2, mem_to_reg2;
  logic [D_WIDTH-1:0] alu1, wdata1, alu2, wdata2;
  logic [D_WIDTH-1:0] dmem_rdata;
  logic [D_WIDTH-1:0] dmem_addr, dmem_wdata;
  logic               dmem_we, dmem_re;
  logic [D_WIDTH-1:0] read_data1, read_data2;
  logic               stall;
  logic [CNT_W-1:0]   conflict_cnt;

  logic [D_WIDTH-1:0] mem [0:255];
  int                 we_pulses = 0;
  int                 tests     = 0;
  int                 failed    = 0;
  int                 we_before;

  always #5 clk = ~clk;

  mem_port_arbiter #(.D_WIDTH(D_WIDTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_MemWrite1M  (mem_write1),
    .i_MemtoReg1M  (mem_to_reg1),
    .i_ALUResult1M (alu1),
    .i_WriteData1M (wdata1),
    .i_MemWrite2M  (mem_write2),
    .i_MemtoReg2M  (mem_to_reg2),
    .i_ALUResult2M (alu2),
    .i_WriteData2M (wdata2),
    .i_DMemRData   (dmem_rdata),
    .o_DMemAddr    (dmem_addr),
    .o_DMemWData   (dmem_wdata),
    .o_DMemWE      (dmem_we),
    .o_DMemRE      (dmem_re),
    .o_ReadData1M  (read_data1),
    .o_ReadData2M  (read_data2),
    .o_StallM      (stall),
    .o_ConflictCnt (conflict_cnt)
  );

  assign dmem_rdata = mem[dmem_addr[7:0]];

  always @(posedge clk) begin
    if (dmem_we) begin
      mem[dmem_addr[7:0]] <= dmem_wdata;
      we_pulses <= we_pulses + 1;
    end
  end

  task automatic check(input string tag, input logic [D_WIDTH-1:0] obs,
                       input logic [D_WIDTH-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic lanes(input logic w1, r1, input logic [D_WIDTH-1:0] a1, d1,
                       input logic w2, r2, input logic [D_WIDTH-1:0] a2, d2);
    mem_write1 = w1; mem_to_reg1 = r1; alu1 = a1; wdata1 = d1;
    mem_write2 = w2; mem_to_reg2 = r2; alu2 = a2; wdata2 = d2;
    #1;
  endtask

  task automatic idle_lanes();
    lanes(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // Advance one clock and leave time just past the edge for new stimulus.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h20] = 32'd5;
    mem[8'h24] = 32'd9;

    rst_n = 1'b0;
    idle_lanes();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_we", {31'b0, dmem_we}, 32'd0);
    check("rst_re", {31'b0, dmem_re}, 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_rd1", read_data1, 32'd0);
    check("rst_rd2", read_data2, 32'd0);
    check("rst_cnt", 32'(conflict_cnt), 32'd0);

    // Lane-1-only store.
    tick();
    lanes(1'b1, 1'b0, 32'h10, 32'hAA, 1'b0, 1'b0, 32'h44, 32'h66);
    check("st1_we", {31'b0, dmem_we}, 32'd1);
    check("st1_addr", dmem_addr, 32'h10);
    check("st1_wdata", dmem_wdata, 32'hAA);
    check("st1_stall", {31'b0, stall}, 32'd0);
    tick();
    idle_lanes();
    check("st1_cnt", 32'(conflict_cnt), 32'd0);
    check("st1_mem", mem[8'h10], 32'hAA);

    // Lane-2-only store served immediately.
    lanes(1'b0, 1'b0, 32'h18, 32'h77, 1'b1, 1'b0, 32'h14, 32'h55);
    check("st2_we", {31'b0, dmem_we}, 32'd1);
    check("st2_addr", dmem_addr, 32'h14);
    check("st2_wdata", dmem_wdata, 32'h55);
    check("st2_stall", {31'b0, stall}, 32'd0);
    check("st2_rd1", read_data1, 32'd0);
    tick();
    check("st2_mem", mem[8'h14], 32'h55);

    // Single-lane loads.
    lanes(1'b0, 1'b1, 32'h10, '0, 1'b0, 1'b0, '0, '0);
    check("ld1_re", {31'b0, dmem_re}, 32'd1);
    check("ld1_rd1", read_data1, 32'hAA);
    check("ld1_rd2", read_data2, 32'd0);
    tick();
    lanes(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 32'h14, '0);
    check("ld2_rd2", read_data2, 32'h55);
    check("ld2_rd1", read_data1, 32'd0);
    check("ld2_stall", {31'b0, stall}, 32'd0);
    tick();

    // Dual load: lane 1 first with stall, lane 2 next cycle.
    lanes(1'b0, 1'b1, 32'h20, '0, 1'b0, 1'b1, 32'h24, '0);
    check("dl_n_stall", {31'b0, stall}, 32'd1);
    check("dl_n_addr", dmem_addr, 32'h20);
    check("dl_n_rd2", read_data2, 32'd0);
    tick();
    check("dl_n1_stall", {31'b0, stall}, 32'd0);
    check("dl_n1_addr", dmem_addr, 32'h24);
    check("dl_n1_rd1", read_data1, 32'd5);
    check("dl_n1_rd2", read_data2, 32'd9);
    check("dl_n1_cnt", 32'(conflict_cnt), 32'd1);
    tick();
    idle_lanes();
    check("dl_after_stall", {31'b0, stall}, 32'd0);
    check("dl_after_addr", dmem_addr, 32'd0);

    // Lane-1 store then lane-2 load of the same address.
    we_before = we_pulses;
    lanes(1'b1, 1'b0, 32'h30, 32'h7, 1'b0, 1'b1, 32'h30, '0);
    check("raw_n_we", {31'b0, dmem_we}, 32'd1);
    check("raw_n_stall", {31'b0, stall}, 32'd1);
    tick();
    check("raw_n1_we", {31'b0, dmem_we}, 32'd0);
    check("raw_n1_re", {31'b0, dmem_re}, 32'd1);
    check("raw_n1_rd2", read_data2, 32'h7);
    check("raw_n1_cnt", 32'(conflict_cnt), 32'd2);
    tick();
    idle_lanes();
    check("raw_we_pulses", 32'(we_pulses - we_before), 32'd1);

    // Reset while serving lane 2.
    lanes(1'b0, 1'b1, 32'h20, '0, 1'b0, 1'b1, 32'h24, '0);
    tick();
    check("rs_in_serve2", {31'b0, stall}, 32'd0);
    rst_n = 1'b0;
    idle_lanes();
    tick();
    rst_n = 1'b1;
    #1;
    check("rs_stall", {31'b0, stall}, 32'd0);
    check("rs_cnt", 32'(conflict_cnt), 32'd0);
    check("rs_rd1", read_data1, 32'd0);
    check("rs_addr", dmem_addr, 32'd0);
    lanes(1'b0, 1'b1, 32'h20, '0, 1'b0, 1'b1, 32'h24, '0);
    check("rs_idle_dual_stall", {31'b0, stall}, 32'd1);

    // Back-to-back conflicts with stable inputs until the counter saturates.
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      tick();
      tick();
      if (i == 13) check("sat_cnt14", 32'(conflict_cnt), 32'd14);
      if (i == 14) check("sat_cnt15", 32'(conflict_cnt), 32'd15);
    end
    check("sat_hold", 32'(conflict_cnt), 32'hF);
    check("sat_stall_again", {31'b0, stall}, 32'd1);

    idle_lanes();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
